// File: rtl/lsu_stage.sv
// lsu_stage: converts RV32I byte/halfword/word loads and stores into accesses
// on a word-addressed data memory that has a combinational read port and a
// single full-word write strobe. Sub-word stores take a two-cycle
// read-modify-write, and loads that straddle a word boundary take a two-cycle
// split read. stall_o holds the PC for the extra cycle.
module lsu_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemRW,
   input  logic        MemRd,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr_i,
   input  logic [31:0] w_data_i,
   input  logic [31:0] mem_r_data_i,
   output logic [31:0] mem_addr_o,
   output logic        mem_we_o,
   output logic [31:0] mem_w_data_o,
   output logic [31:0] r_data_o,
   output logic        stall_o,
   output logic        err_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LD_HI = 2'd1,
      ST_WR = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [29:0] a_q;
   logic [1:0]  off_q;
   logic [2:0]  f3_q;
   logic [31:0] lo_q, lo_d;
   logic [31:0] merged_q, merged_d;
   logic        latch_en;

   logic [1:0]  off_s;
   logic [29:0] a_s;
   logic [4:0]  sh_lo_s;
   logic [5:0]  sh_hi_s;
   logic [31:0] joined_s;

   // Sign/zero extension of the low bytes of a gathered load value.
   function automatic logic [31:0] load_ext(input logic [31:0] v, input logic [2:0] f3);
      logic [31:0] res;
      case (f3)
         3'd0:    res = {{24{v[7]}}, v[7:0]};
         3'd1:    res = {{16{v[15]}}, v[15:0]};
         3'd2:    res = v;
         3'd4:    res = {24'd0, v[7:0]};
         3'd5:    res = {16'd0, v[15:0]};
         default: res = 32'd0;
      endcase
      return res;
   endfunction

   // True for the load encodings this unit accepts (B, H, W, BU, HU).
   function automatic logic load_ok(input logic [2:0] f3);
      logic ok;
      case (f3)
         3'd0, 3'd1, 3'd2, 3'd4, 3'd5: ok = 1'b1;
         default:                      ok = 1'b0;
      endcase
      return ok;
   endfunction

   // True when off + size exceeds the four bytes of one word.
   function automatic logic load_crosses(input logic [1:0] off, input logic [2:0] f3);
      logic c;
      case (f3)
         3'd1, 3'd5: c = (off == 2'd3);
         3'd2:       c = (off != 2'd0);
         default:    c = 1'b0;
      endcase
      return c;
   endfunction

   // Replace the target byte lanes of word with the low bytes of data.
   function automatic logic [31:0] merge_word(input logic [31:0] word, input logic [31:0] data,
                                              input logic [1:0] off, input logic [2:0] f3);
      logic [31:0] mask;
      logic [4:0]  sh;
      sh   = {off, 3'b000};
      mask = (f3 == 3'd0) ? 32'h0000_00FF : 32'h0000_FFFF;
      mask = mask << sh;
      return (word & ~mask) | ((data << sh) & mask);
   endfunction

   assign off_s    = addr_i[1:0];
   assign a_s      = addr_i[31:2];
   assign sh_lo_s  = {off_s, 3'b000};
   assign sh_hi_s  = 6'd32 - {1'b0, off_q, 3'b000};
   assign lo_d     = mem_r_data_i >> sh_lo_s;
   assign merged_d = merge_word(mem_r_data_i, w_data_i, off_s, funct3);
   // lo holds bytes off..3 packed at byte 0; the next word's bytes follow them.
   assign joined_s = lo_q | (mem_r_data_i << sh_hi_s);

   // Next-state and output decode; reset forces all strobes and data low at once.
   always_comb begin
      state_d      = state_q;
      latch_en     = 1'b0;
      mem_addr_o   = {2'b00, a_s};
      mem_we_o     = 1'b0;
      mem_w_data_o = 32'd0;
      r_data_o     = 32'd0;
      stall_o      = 1'b0;
      err_o        = 1'b0;
      case (state_q)
         IDLE: begin
            if (MemRW) begin
               latch_en = 1'b1;
               case (funct3)
                  3'd0: begin
                     stall_o = 1'b1;
                     state_d = ST_WR;
                  end
                  3'd1: begin
                     if (off_s != 2'd3) begin
                        stall_o = 1'b1;
                        state_d = ST_WR;
                     end else begin
                        err_o = 1'b1;
                     end
                  end
                  3'd2: begin
                     if (off_s == 2'd0) begin
                        mem_we_o     = 1'b1;
                        mem_w_data_o = w_data_i;
                     end else begin
                        err_o = 1'b1;
                     end
                  end
                  default: err_o = 1'b1;
               endcase
            end else if (MemRd) begin
               latch_en = 1'b1;
               if (!load_ok(funct3)) begin
                  err_o = 1'b1;
               end else if (load_crosses(off_s, funct3)) begin
                  stall_o = 1'b1;
                  state_d = LD_HI;
               end else begin
                  r_data_o = load_ext(lo_d, funct3);
               end
            end else begin
               state_d = IDLE;
            end
         end
         LD_HI: begin
            mem_addr_o = {2'b00, a_q + 30'd1};
            r_data_o   = load_ext(joined_s, f3_q);
            state_d    = IDLE;
         end
         ST_WR: begin
            mem_addr_o   = {2'b00, a_q};
            mem_we_o     = 1'b1;
            mem_w_data_o = merged_q;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (rst) begin
         mem_we_o     = 1'b0;
         mem_w_data_o = 32'd0;
         r_data_o     = 32'd0;
         stall_o      = 1'b0;
         err_o        = 1'b0;
         state_d      = IDLE;
      end else begin
         latch_en = latch_en;
      end
   end

   // State register plus request capture taken only on an IDLE request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         a_q      <= 30'd0;
         off_q    <= 2'd0;
         f3_q     <= 3'd0;
         lo_q     <= 32'd0;
         merged_q <= 32'd0;
      end else begin
         state_q <= state_d;
         if (latch_en) begin
            a_q      <= a_s;
            off_q    <= off_s;
            f3_q     <= funct3;
            lo_q     <= lo_d;
            merged_q <= merged_d;
         end
      end
   end

endmodule

// File: tb/tb_lsu_stage.sv
// Testbench for lsu_stage: table of single-cycle IDLE vectors checked through
// an expected-result queue, plus hand sequences for split loads, read-modify-
// write stores and reset during a store.
module tb_lsu_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        MemRW, MemRd;
   logic [2:0]  funct3;
   logic [31:0] addr, w_data, mem_r_data;
   logic [31:0] mem_addr, mem_w_data, r_data;
   logic        mem_we, stall, err;

   logic [31:0] mem [0:63];
   logic        pl_en = 1'b0;
   logic [5:0]  pl_idx = 6'd0;
   logic [31:0] pl_val = 32'd0;

   int pass_cnt = 0;
   int total_cnt = 0;

   typedef struct packed {
      logic        rw;
      logic        rd;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        stall;
      logic        err;
      logic        we;
      logic [31:0] wdo;
      logic [31:0] rdo;
      logic [31:0] maddr;
   } vec_t;

   vec_t vecs [0:16];
   vec_t exp_q [$];

   lsu_stage dut (
      .clk          (clk),
      .rst          (rst),
      .MemRW        (MemRW),
      .MemRd        (MemRd),
      .funct3       (funct3),
      .addr_i       (addr),
      .w_data_i     (w_data),
      .mem_r_data_i (mem_r_data),
      .mem_addr_o   (mem_addr),
      .mem_we_o     (mem_we),
      .mem_w_data_o (mem_w_data),
      .r_data_o     (r_data),
      .stall_o      (stall),
      .err_o        (err)
   );

   always #5 clk = ~clk;

   assign mem_r_data = mem[mem_addr[5:0]];

   // Data memory model: preload port or DUT write strobe.
   always @(posedge clk) begin
      if (pl_en) mem[pl_idx] <= pl_val;
      else if (mem_we) mem[mem_addr[5:0]] <= mem_w_data;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic drive(input logic rw, input logic rd, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
      MemRW = rw; MemRd = rd; funct3 = f3; addr = a; w_data = wd;
   endtask

   task automatic preload(input logic [5:0] idx, input logic [31:0] val);
      pl_en = 1'b1; pl_idx = idx; pl_val = val;
      @(posedge clk); #1;
      pl_en = 1'b0;
   endtask

   function automatic vec_t mkv(input logic rw, input logic rd, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic st, input logic er, input logic we,
                                input logic [31:0] wdo, input logic [31:0] rdo,
                                input logic [31:0] ma);
      vec_t v;
      v.rw = rw; v.rd = rd; v.f3 = f3; v.addr = a; v.wd = wd;
      v.stall = st; v.err = er; v.we = we; v.wdo = wdo; v.rdo = rdo; v.maddr = ma;
      return v;
   endfunction

   initial begin
      vec_t e;
      //               rw    rd    f3    addr          wdata         stall err   we    wdata_o       rdata_o       maddr
      vecs[0]  = mkv(1'b0, 1'b0, 3'd0, 32'h0000_0020, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'd8);
      vecs[1]  = mkv(1'b0, 1'b1, 3'd2, 32'h0000_0020, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'hDEADBEEF, 32'd8);
      vecs[2]  = mkv(1'b0, 1'b1, 3'd0, 32'h0000_000F, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'hFFFFFFAA, 32'd3);
      vecs[3]  = mkv(1'b0, 1'b1, 3'd4, 32'h0000_000F, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h000000AA, 32'd3);
      vecs[4]  = mkv(1'b0, 1'b1, 3'd1, 32'h0000_000E, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'hFFFFAABB, 32'd3);
      vecs[5]  = mkv(1'b0, 1'b1, 3'd5, 32'h0000_000E, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h0000AABB, 32'd3);
      vecs[6]  = mkv(1'b0, 1'b1, 3'd0, 32'h0000_000C, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'hFFFFFFDD, 32'd3);
      vecs[7]  = mkv(1'b0, 1'b1, 3'd4, 32'h0000_000D, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h000000CC, 32'd3);
      vecs[8]  = mkv(1'b0, 1'b1, 3'd1, 32'h0000_000C, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'hFFFFCCDD, 32'd3);
      vecs[9]  = mkv(1'b0, 1'b1, 3'd2, 32'h0000_0010, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h11223344, 32'd4);
      vecs[10] = mkv(1'b1, 1'b0, 3'd1, 32'h0000_000F, 32'h1234,     1'b0, 1'b1, 1'b0, 32'h0,        32'h0,        32'd3);
      vecs[11] = mkv(1'b1, 1'b0, 3'd2, 32'h0000_0021, 32'h5555AAAA, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0,        32'd8);
      vecs[12] = mkv(1'b1, 1'b0, 3'd3, 32'h0000_0020, 32'h12345678, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0,        32'd8);
      vecs[13] = mkv(1'b0, 1'b1, 3'd6, 32'h0000_0020, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        32'h0,        32'd8);
      vecs[14] = mkv(1'b0, 1'b1, 3'd3, 32'h0000_000C, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        32'h0,        32'd3);
      vecs[15] = mkv(1'b1, 1'b1, 3'd2, 32'h0000_0020, 32'hCAFEF00D, 1'b0, 1'b0, 1'b1, 32'hCAFEF00D, 32'h0,        32'd8);
      vecs[16] = mkv(1'b0, 1'b1, 3'd2, 32'h0000_0020, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'hCAFEF00D, 32'd8);

      // Reset: outputs quiet even with requests present.
      rst = 1'b1;
      drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
      preload(6'd3,  32'hAABBCCDD);
      preload(6'd4,  32'h11223344);
      preload(6'd8,  32'hDEADBEEF);
      preload(6'd63, 32'h01020304);
      preload(6'd0,  32'h55667788);
      drive(1'b1, 1'b0, 3'd2, 32'h0000_0020, 32'h12345678);
      #2;
      check("rst_sw_we",  32'(mem_we), 32'd0);
      check("rst_sw_wd",  mem_w_data,  32'd0);
      drive(1'b1, 1'b0, 3'd1, 32'h0000_000F, 32'h0);
      #1;
      check("rst_sh_err", 32'(err), 32'd0);
      drive(1'b0, 1'b1, 3'd2, 32'h0000_000E, 32'h0);
      #1;
      check("rst_lw_stall", 32'(stall), 32'd0);
      check("rst_lw_rdata", r_data,     32'd0);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
      rst = 1'b0;

      // Table vectors through the expected-result queue.
      for (int i = 0; i < 17; i++) begin
         @(posedge clk); #1;
         drive(vecs[i].rw, vecs[i].rd, vecs[i].f3, vecs[i].addr, vecs[i].wd);
         exp_q.push_back(vecs[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         check($sformatf("v%0d_stall", i), 32'(stall),  32'(e.stall));
         check($sformatf("v%0d_err", i),   32'(err),    32'(e.err));
         check($sformatf("v%0d_we", i),    32'(mem_we), 32'(e.we));
         check($sformatf("v%0d_wdata", i), mem_w_data,  e.wdo);
         check($sformatf("v%0d_rdata", i), r_data,      e.rdo);
         check($sformatf("v%0d_maddr", i), mem_addr,    e.maddr);
      end
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);

      // Crossing LW at 0x0E.
      @(posedge clk); #1;
      drive(1'b0, 1'b1, 3'd2, 32'h0000_000E, 32'h0);
      @(negedge clk);
      check("xlw_c0_stall", 32'(stall), 32'd1);
      check("xlw_c0_maddr", mem_addr,   32'd3);
      @(negedge clk);
      check("xlw_c1_stall", 32'(stall), 32'd0);
      check("xlw_c1_maddr", mem_addr,   32'd4);
      check("xlw_c1_rdata", r_data,     32'h3344AABB);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
      @(negedge clk);
      check("xlw_c2_stall", 32'(stall), 32'd0);
      check("xlw_c2_maddr", mem_addr,   32'd0);

      // Crossing LH at 0x0F.
      @(posedge clk); #1;
      drive(1'b0, 1'b1, 3'd1, 32'h0000_000F, 32'h0);
      @(negedge clk);
      check("xlh_c0_stall", 32'(stall), 32'd1);
      @(negedge clk);
      check("xlh_c1_rdata", r_data,     32'h000044AA);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);

      // Crossing LW at the top of the address space wraps to word 0.
      @(posedge clk); #1;
      drive(1'b0, 1'b1, 3'd2, 32'hFFFF_FFFE, 32'h0);
      @(negedge clk);
      check("wrap_c0_maddr", mem_addr, 32'h3FFF_FFFF);
      @(negedge clk);
      check("wrap_c1_maddr", mem_addr, 32'd0);
      check("wrap_c1_rdata", r_data,   32'h77880102);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);

      // SB at 0x11: read-modify-write of word 4.
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 3'd0, 32'h0000_0011, 32'h000000AB);
      @(negedge clk);
      check("sb_c0_stall", 32'(stall),  32'd1);
      check("sb_c0_we",    32'(mem_we), 32'd0);
      check("sb_c0_maddr", mem_addr,    32'd4);
      @(negedge clk);
      check("sb_c1_we",    32'(mem_we), 32'd1);
      check("sb_c1_stall", 32'(stall),  32'd0);
      check("sb_c1_maddr", mem_addr,    32'd4);
      check("sb_c1_wdata", mem_w_data,  32'h1122AB44);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
      check("sb_mem", mem[4], 32'h1122AB44);

      // Restore word 4 with an aligned SW.
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 3'd2, 32'h0000_0010, 32'h11223344);
      @(negedge clk);
      check("sw_we", 32'(mem_we), 32'd1);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
      check("sw_mem", mem[4], 32'h11223344);

      // Reset asserted during ST_WR blocks the write.
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 3'd0, 32'h0000_0011, 32'h00000055);
      @(negedge clk);
      check("rsw_c0_stall", 32'(stall), 32'd1);
      @(posedge clk); #1;
      check("rsw_c1_we_pre", 32'(mem_we), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("rsw_we_drop",  32'(mem_we), 32'd0);
      check("rsw_stall",    32'(stall),  32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      drive(1'b0, 1'b0, 3'd0, 32'h0000_0010, 32'h0);
      @(negedge clk);
      check("rsw_mem",   mem[4],      32'h11223344);
      check("rsw_maddr", mem_addr,    32'd4);
      check("rsw_idle_we", 32'(mem_we), 32'd0);
      @(posedge clk); #1;
      drive(1'b0, 1'b1, 3'd2, 32'h0000_0010, 32'h0);
      @(negedge clk);
      check("rsw_lw_stall", 32'(stall), 32'd0);
      check("rsw_lw_rdata", r_data,     32'h11223344);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
